// File: rtl/alu_cmd_seq_pkg.sv
// Shared definitions for the ALU command sequencer.
//   OP_*        : 3-bit ALU control codes driven on alu_ctrl
//   state_e     : sequencer FSM states
//   cmd_entry_t : one queued command; operand fields are MAX_W wide so the
//                 struct can be shared by any instance with W <= MAX_W
//                 (only the low W bits are meaningful).
package alu_cmd_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]       op;
        logic [MAX_W-1:0] a;
        logic [MAX_W-1:0] b;
        logic             use_acc;
    } cmd_entry_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue for alu_cmd_seq.
//   push/push_data : write one entry (ignored while full)
//   pop/pop_data   : pop_data shows the head; pop advances it (ignored while empty)
//   full/empty     : occupancy flags
// Only the low W operand bits are stored; pop_data zero-extends them.
module alu_cmd_fifo
    import alu_cmd_seq_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  cmd_entry_t push_data,
    input  logic       pop,
    output cmd_entry_t pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * W + 4;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] wr_word;
    logic [EW-1:0] rd_word;
    logic          unused_hi;

    assign unused_hi = ^{push_data.a, push_data.b};
    assign wr_word   = {push_data.op, push_data.a[W-1:0], push_data.b[W-1:0], push_data.use_acc};
    assign rd_word   = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        pop_data         = '0;
        pop_data.op      = rd_word[EW-1 -: 3];
        pop_data.a       = MAX_W'(rd_word[2*W : W+1]);
        pop_data.b       = MAX_W'(rd_word[W : 1]);
        pop_data.use_acc = rd_word[0];
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr_q[AW-1:0]] <= wr_word;
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: queues commands, drives an external combinational
// ALU through registered operands, captures its result and flags into a
// response register held until rsp_ready, and keeps an accumulator plus a
// completed-response counter.
//   cmd_*          : command handshake and payload (cmd_use_acc swaps a for acc)
//   acc_clr        : synchronous accumulator clear, wins over a result load
//   alu_a/b/ctrl   : registered ALU drive; alu_res/car/of come back combinationally
//   rsp_*          : response handshake, result, flags, zero flag
//   acc, op_cnt    : accumulator and wrapping 8-bit response count
//   busy           : FSM active or commands still queued
module alu_cmd_seq
    import alu_cmd_seq_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_use_acc,
    input  logic         acc_clr,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_ctrl,
    input  logic [W-1:0] alu_res,
    input  logic         alu_car,
    input  logic         alu_of,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_res,
    output logic         rsp_car,
    output logic         rsp_of,
    output logic         rsp_zero,
    output logic [W-1:0] acc,
    output logic [7:0]   op_cnt,
    output logic         busy
);

    state_e     state_q, state_d;
    cmd_entry_t push_entry, head;
    logic       fifo_full, fifo_empty, pop, rsp_hs, unused_hi;

    logic [W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_res_q, rsp_res_d, acc_q, acc_d;
    logic [2:0]   alu_ctrl_q, alu_ctrl_d;
    logic         rsp_valid_q, rsp_valid_d, rsp_car_q, rsp_car_d;
    logic         rsp_of_q, rsp_of_d, rsp_zero_q, rsp_zero_d;
    logic [7:0]   op_cnt_q, op_cnt_d;

    always_comb begin
        push_entry         = '0;
        push_entry.op      = cmd_op;
        push_entry.a       = MAX_W'(cmd_a);
        push_entry.b       = MAX_W'(cmd_b);
        push_entry.use_acc = cmd_use_acc;
    end

    alu_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (cmd_valid && cmd_ready),
        .push_data(push_entry),
        .pop      (pop),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign unused_hi = ^{head.a, head.b};
    assign cmd_ready = !fifo_full;
    assign rsp_hs    = (state_q == RESP) && rsp_ready;
    // Every entry into ISSUE pops the head.
    assign pop       = !fifo_empty && ((state_q == IDLE) || rsp_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = fifo_empty ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_car_d   = rsp_car_q;
        rsp_of_d    = rsp_of_q;
        rsp_zero_d  = rsp_zero_q;
        acc_d       = acc_q;
        op_cnt_d    = op_cnt_q;
        // acc_q already holds the previous result here, since the result
        // load on leaving ISSUE always precedes the next pop.
        if (pop) begin
            alu_a_d    = head.use_acc ? acc_q : head.a[W-1:0];
            alu_b_d    = head.b[W-1:0];
            alu_ctrl_d = head.op;
        end
        if (state_q == ISSUE) begin
            rsp_valid_d = 1'b1;
            rsp_res_d   = alu_res;
            rsp_car_d   = alu_car;
            rsp_of_d    = alu_of;
            rsp_zero_d  = (alu_res == '0);
            acc_d       = alu_res;
        end
        if (rsp_hs) begin
            rsp_valid_d = 1'b0;
            op_cnt_d    = op_cnt_q + 8'd1;
        end
        if (acc_clr) acc_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_car_q   <= 1'b0;
            rsp_of_q    <= 1'b0;
            rsp_zero_q  <= 1'b1;
            acc_q       <= '0;
            op_cnt_q    <= '0;
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_car_q   <= rsp_car_d;
            rsp_of_q    <= rsp_of_d;
            rsp_zero_q  <= rsp_zero_d;
            acc_q       <= acc_d;
            op_cnt_q    <= op_cnt_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_car   = rsp_car_q;
    assign rsp_of    = rsp_of_q;
    assign rsp_zero  = rsp_zero_q;
    assign acc       = acc_q;
    assign op_cnt    = op_cnt_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq with a behavioural ALU attached.
module tb_alu_cmd_seq;
    localparam int W     = 4;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0, cmd_use_acc = 1'b0, acc_clr = 1'b0, rsp_ready = 1'b0;
    logic [2:0]   cmd_op = '0;
    logic [W-1:0] cmd_a = '0, cmd_b = '0;
    logic         cmd_ready, alu_car, alu_of, rsp_valid, rsp_car, rsp_of, rsp_zero, busy;
    logic [W-1:0] alu_a, alu_b, alu_res, rsp_res, acc;
    logic [2:0]   alu_ctrl;
    logic [7:0]   op_cnt;

    always #5 clk = ~clk;

    alu_cmd_seq #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .acc_clr(acc_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res), .alu_car(alu_car), .alu_of(alu_of),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
        .rsp_car(rsp_car), .rsp_of(rsp_of), .rsp_zero(rsp_zero),
        .acc(acc), .op_cnt(op_cnt), .busy(busy)
    );

    // Behavioural ALU: returns {carry, overflow, result}. Sub carry = borrow.
    function automatic logic [W+1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, o;
        c = 1'b0; o = 1'b0; r = '0; s = '0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; c = s[W];
                o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1: begin
                r = a - b; c = (a < b);
                o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = {{(W-1){1'b0}}, (a < b)};
            default: r = {{(W-1){1'b0}}, (a == b)};
        endcase
        return {c, o, r};
    endfunction

    assign {alu_car, alu_of, alu_res} = alu_fn(alu_ctrl, alu_a, alu_b);

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out", nm);
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ua);
        bit rdy;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); rdy = cmd_ready;
            @(posedge clk); #1;
            if (rdy) begin cmd_valid = 1'b0; return; end
        end
        cmd_valid = 1'b0;
        timeout("send");
    endtask

    task automatic wait_rsp(input string nm, output int lat);
        lat = 0;
        while (!rsp_valid) begin
            @(posedge clk); #1; lat++;
            if (lat > 30) begin timeout(nm); return; end
        end
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset;
        #2 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic drain;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!busy && !rsp_valid) return;
            step();
        end
        timeout("drain");
    endtask

    // Reference model: in-order queue of accepted commands and a model
    // accumulator; every response handshake is checked against it.
    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic         ua;
    } cmd_t;
    cmd_t         sbq[$];
    cmd_t         e;
    logic [W-1:0] macc, ea;
    logic [W+1:0] r;
    int           mcnt = 0;
    bit           sb_en = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete(); macc = '0; mcnt = 0;
        end else if (sb_en) begin
            if (cmd_valid && cmd_ready) sbq.push_back('{cmd_op, cmd_a, cmd_b, cmd_use_acc});
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_underflow: response with no command outstanding");
                end else begin
                    e  = sbq.pop_front();
                    ea = e.ua ? macc : e.a;
                    r  = alu_fn(e.op, ea, e.b);
                    chk("sb_res", rsp_res, r[W-1:0]);
                    chk("sb_car", rsp_car, r[W+1]);
                    chk("sb_of", rsp_of, r[W]);
                    chk("sb_zero", rsp_zero, r[W-1:0] == '0);
                    chk("sb_acc", acc, r[W-1:0]);
                    chk("sb_cnt", op_cnt, mcnt[7:0]);
                    macc = r[W-1:0];
                    mcnt++;
                end
            end
        end
    end

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, res;
        logic         car, of, zero;
    } vec_t;
    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           lat, got, hs_at_acc;
        bit           acc4, seen;
        logic [W-1:0] exp_r[4];
        bit           done;

        tbl[0]  = '{3'd0, 4'h7, 4'h9, 4'h0, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{3'd0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{3'd0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{3'd1, 4'h3, 4'h5, 4'hE, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{3'd1, 4'h8, 4'h1, 4'h7, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{3'd2, 4'h5, 4'h0, 4'hA, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{3'd3, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{3'd4, 4'hC, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3'd5, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{3'd6, 4'h3, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{3'd7, 4'h6, 4'h6, 4'h1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{3'd7, 4'h6, 4'h7, 4'h0, 1'b0, 1'b0, 1'b1};

        // Reset values
        #12;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_res", rsp_res, 0);
        chk("rst_rsp_flags", {rsp_car, rsp_of, rsp_zero}, 3'b001);
        chk("rst_alu", {alu_a, alu_b, alu_ctrl}, 0);
        chk("rst_acc", acc, 0);
        chk("rst_op_cnt", op_cnt, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single-command vectors from idle, rsp_ready held high
        rsp_ready = 1'b1;
        foreach (tbl[i]) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
            wait_rsp("vec_wait", lat);
            chk($sformatf("vec%0d_lat", i), lat, 2);
            chk($sformatf("vec%0d_res", i), rsp_res, tbl[i].res);
            chk($sformatf("vec%0d_flags", i), {rsp_car, rsp_of, rsp_zero}, {tbl[i].car, tbl[i].of, tbl[i].zero});
            chk($sformatf("vec%0d_acc", i), acc, tbl[i].res);
            step();
            chk($sformatf("vec%0d_drop", i), rsp_valid, 0);
        end
        chk("vec_op_cnt", op_cnt, 12);

        // Accumulator chaining
        pulse_reset();
        send(3'd1, 4'h3, 4'h5, 1'b0);
        wait_rsp("chain1", lat);
        chk("chain1_res", rsp_res, 4'hE);
        step();
        send(3'd0, 4'h9, 4'h2, 1'b1);
        wait_rsp("chain2", lat);
        chk("chain2_alu_a", alu_a, 4'hE);
        chk("chain2_res", rsp_res, 4'h0);
        chk("chain2_car", rsp_car, 1);
        step();
        chk("chain_op_cnt", op_cnt, 2);

        // Back-pressure: stall a response, fill the FIFO, hold a fourth command
        pulse_reset();
        rsp_ready = 1'b0;
        send(3'd0, 4'h1, 4'h1, 1'b0);
        wait_rsp("bp_first", lat);
        send(3'd0, 4'h2, 4'h2, 1'b0);
        send(3'd0, 4'h3, 4'h3, 1'b0);
        chk("bp_full_ready", cmd_ready, 0);
        cmd_op = 3'd0; cmd_a = 4'h4; cmd_b = 4'h4; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        repeat (3) step();
        chk("bp_held_ready", cmd_ready, 0);
        chk("bp_held_valid", rsp_valid, 1);
        exp_r[0] = 4'h2; exp_r[1] = 4'h4; exp_r[2] = 4'h6; exp_r[3] = 4'h8;
        got = 0; hs_at_acc = -1;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            acc4 = cmd_valid && cmd_ready;
            if (acc4) hs_at_acc = got;
            if (rsp_valid && rsp_ready) begin
                chk($sformatf("bp_order%0d", got), rsp_res, exp_r[got]);
                got++;
            end
            @(posedge clk); #1;
            if (acc4) cmd_valid = 1'b0;
        end
        if (got < 4) timeout("bp_responses");
        chk("bp_accept_after_hs", hs_at_acc, 1);

        // Asynchronous reset while in ISSUE
        send(3'd0, 4'h5, 4'h6, 1'b0);
        step();
        chk("rst_mid_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", rsp_valid, 0);
        chk("rst_mid_acc", acc, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        chk("rst_mid_alu_a", alu_a, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin step(); seen |= rsp_valid; end
        chk("rst_mid_no_rsp", seen, 0);
        send(3'd0, 4'h2, 4'h3, 1'b0);
        wait_rsp("rst_after", lat);
        chk("rst_after_lat", lat, 2);
        chk("rst_after_res", rsp_res, 4'h5);
        step();

        // acc_clr coinciding with the capture of a result of 5
        send(3'd0, 4'h1, 4'h4, 1'b0);
        step();
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        chk("clr_valid", rsp_valid, 1);
        chk("clr_res", rsp_res, 4'h5);
        chk("clr_acc", acc, 0);
        step();

        // 256 back-to-back random commands against the model
        pulse_reset();
        sb_en = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++)
            send(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom));
        drain();
        chk("b2b_op_cnt_wrap", op_cnt, 0);
        chk("b2b_model_empty", sbq.size(), 0);

        // Random gaps and random rsp_ready
        pulse_reset();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    send(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom);
                end
            end
        join
        drain();
        chk("rnd_model_empty", sbq.size(), 0);
        chk("rnd_op_cnt", op_cnt, 150);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
